// File: rtl/param_assoc_cache.sv
// Write-back, write-allocate N-way set-associative cache between a 32-bit CPU port
// and a line-wide physical memory port, with tree pseudo-LRU replacement.
module param_assoc_cache #(
    parameter int unsigned OFFSET_BITS = 5,
    parameter int unsigned INDEX_BITS  = 3,
    parameter int unsigned WAYS        = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       mem_address,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [3:0]                        mem_byte_enable,
    input  logic [31:0]                       mem_wdata,
    output logic [31:0]                       mem_rdata,
    output logic                              mem_resp,
    output logic [31:0]                       pmem_address,
    output logic                              pmem_read,
    output logic                              pmem_write,
    output logic [(8 << OFFSET_BITS)-1:0]     pmem_wdata,
    input  logic [(8 << OFFSET_BITS)-1:0]     pmem_rdata,
    input  logic                              pmem_resp
);
    localparam int unsigned LINE_BITS = 8 << OFFSET_BITS;
    localparam int unsigned SETS      = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS  = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned PLRU_W    = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int unsigned WORD_BITS = OFFSET_BITS - 2;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITEBACK, S_FILL} state_t;

    state_t                state_q, state_d;
    logic [31:2]           addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic [WAY_BITS-1:0]   victim_q, victim_d;
    logic [31:0]           paddr_q, paddr_d;
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       valid_d [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WAYS-1:0]       dirty_d [SETS];
    logic [PLRU_W-1:0]     plru_q  [SETS];
    logic [PLRU_W-1:0]     plru_d  [SETS];

    // Tag and data storage carry no reset; valid bits qualify them.
    logic [TAG_BITS-1:0]   tag_mem  [SETS][WAYS];
    logic [LINE_BITS-1:0]  data_mem [SETS][WAYS];

    logic                  tag_we, data_we;
    logic [WAY_BITS-1:0]   arr_way;
    logic [LINE_BITS-1:0]  data_line;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [WORD_BITS-1:0]  req_word;
    logic                  hit, inv_found;
    logic [WAY_BITS-1:0]   hit_way, inv_way, victim_sel, plru_victim;
    logic [PLRU_W-1:0]     plru_cur, plru_upd;
    logic [LINE_BITS-1:0]  hit_line, merged_line;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_address[1:0];

    assign req_tag  = addr_q[31 -: TAG_BITS];
    assign req_idx  = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_word = addr_q[OFFSET_BITS-1:2];
    assign plru_cur = plru_q[req_idx];

    // Tag compare, lowest invalid way, and the line to merge a write into.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
        hit_line    = data_mem[req_idx][hit_way];
        merged_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merged_line[32*int'(req_word) + 8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
        victim_sel = inv_found ? inv_way : plru_victim;
    end

    // Tree PLRU: bits name the least-recently-used side; an access points them away.
    generate
        if (WAYS == 4) begin : g_plru4
            assign plru_victim = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                                             : (plru_cur[1] ? 2'd1 : 2'd0);
            always_comb begin
                plru_upd = plru_cur;
                if (!hit_way[1]) begin
                    plru_upd[0] = 1'b1;
                    plru_upd[1] = ~hit_way[0];
                end else begin
                    plru_upd[0] = 1'b0;
                    plru_upd[2] = ~hit_way[0];
                end
            end
        end else if (WAYS == 2) begin : g_plru2
            assign plru_victim = plru_cur;
            assign plru_upd    = ~hit_way;
        end else begin : g_plru1
            assign plru_victim = '0;
            assign plru_upd    = plru_cur;
        end
    endgenerate

    // Next-state and outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        victim_d     = victim_q;
        paddr_d      = paddr_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        plru_d       = plru_q;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        arr_way      = victim_q;
        data_line    = pmem_rdata;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        pmem_address = paddr_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = mem_address[31:2];
                    be_d    = mem_byte_enable;
                    wdata_d = mem_wdata;
                    write_d = mem_write;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit) begin
                    mem_resp        = 1'b1;
                    mem_rdata       = hit_line[32*int'(req_word) +: 32];
                    plru_d[req_idx] = plru_upd;
                    if (write_q) begin
                        data_we                   = 1'b1;
                        arr_way                   = hit_way;
                        data_line                 = merged_line;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    victim_d = victim_sel;
                    if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_mem[req_idx][victim_q], req_idx, OFFSET_BITS'(0)};
                pmem_wdata   = data_mem[req_idx][victim_q];
                paddr_d      = pmem_address;
                if (pmem_resp) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, OFFSET_BITS'(0)};
                paddr_d      = pmem_address;
                if (pmem_resp) begin
                    tag_we                     = 1'b1;
                    data_we                    = 1'b1;
                    valid_d[req_idx][victim_q] = 1'b1;
                    dirty_d[req_idx][victim_q] = 1'b0;
                    state_d                    = S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            victim_q <= '0;
            paddr_q  <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            victim_q <= victim_d;
            paddr_q  <= paddr_d;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= valid_d[s];
                dirty_q[s] <= dirty_d[s];
                plru_q[s]  <= plru_d[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[req_idx][arr_way] <= req_tag;
        end
        if (data_we) begin
            data_mem[req_idx][arr_way] <= data_line;
        end
    end

endmodule

// File: tb/tb_param_assoc_cache.sv
// Bench for param_assoc_cache: a 2-way/32B-line instance and a 4-way/16B-line instance,
// a behavioural line memory, a CPU-view word model and a response scoreboard.
module tb_param_assoc_cache;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0]  m_addr [2];
    logic         m_rd   [2];
    logic         m_wr   [2];
    logic [3:0]   m_be   [2];
    logic [31:0]  m_wdata[2];
    logic [31:0]  m_rdata[2];
    logic         m_resp [2];
    logic [31:0]  p_addr [2];
    logic         p_rd   [2];
    logic         p_wr   [2];
    logic         p_resp [2];
    logic [255:0] p_rdata_a, p_wdata_a;
    logic [127:0] p_rdata_b, p_wdata_b;

    param_assoc_cache #(.OFFSET_BITS(5), .INDEX_BITS(3), .WAYS(2)) u_a (
        .clk(clk), .rst(rst),
        .mem_address(m_addr[0]), .mem_read(m_rd[0]), .mem_write(m_wr[0]),
        .mem_byte_enable(m_be[0]), .mem_wdata(m_wdata[0]),
        .mem_rdata(m_rdata[0]), .mem_resp(m_resp[0]),
        .pmem_address(p_addr[0]), .pmem_read(p_rd[0]), .pmem_write(p_wr[0]),
        .pmem_wdata(p_wdata_a), .pmem_rdata(p_rdata_a), .pmem_resp(p_resp[0])
    );

    param_assoc_cache #(.OFFSET_BITS(4), .INDEX_BITS(2), .WAYS(4)) u_b (
        .clk(clk), .rst(rst),
        .mem_address(m_addr[1]), .mem_read(m_rd[1]), .mem_write(m_wr[1]),
        .mem_byte_enable(m_be[1]), .mem_wdata(m_wdata[1]),
        .mem_rdata(m_rdata[1]), .mem_resp(m_resp[1]),
        .pmem_address(p_addr[1]), .pmem_read(p_rd[1]), .pmem_write(p_wr[1]),
        .pmem_wdata(p_wdata_b), .pmem_rdata(p_rdata_b), .pmem_resp(p_resp[1])
    );

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          kind;   // 0 hit, 1 clean miss, 2 dirty miss
        logic [31:0] wb_a;
        logic [31:0] fill_a;
    } vec_t;

    typedef struct {
        int          d;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] a;
    } ev_t;

    exp_t        exp_q[$];
    ev_t         ev_q[$];
    vec_t        vt[$];
    logic [31:0] cpu_mem [logic [32:0]];
    logic [31:0] bk_mem  [logic [32:0]];
    int          cnt[2];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
        end
    endtask

    function automatic logic [32:0] key(input int d, input logic [31:0] a);
        return {d[0], a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] pat(input int d, input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ ((d == 0) ? 32'hA5C3_0F0F : 32'h3C5A_F0F0);
    endfunction

    function automatic logic [31:0] cpu_rd(input int d, input logic [31:0] a);
        if (cpu_mem.exists(key(d, a))) return cpu_mem[key(d, a)];
        return pat(d, a);
    endfunction

    function automatic logic [31:0] bk_rd(input int d, input logic [31:0] a);
        if (bk_mem.exists(key(d, a))) return bk_mem[key(d, a)];
        return pat(d, a);
    endfunction

    function automatic vec_t mk(input int d, input logic wr, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd, input int kind,
                                input logic [31:0] wb, input logic [31:0] fa);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = a; v.be = be; v.wdata = wd;
        v.kind = kind; v.wb_a = wb; v.fill_a = fa;
        return v;
    endfunction

    // Physical memory: answers a held strobe on its third sampled cycle.
    task automatic serve(input int d);
        int           wpl;
        logic [31:0]  base;
        logic [255:0] ln;
        wpl  = (d == 0) ? 8 : 4;
        base = p_addr[d];
        ev_q.push_back('{d, p_wr[d], base});
        chk("line_align", base & 32'(wpl*4 - 1), 0);
        if (p_wr[d]) begin
            ln = (d == 0) ? p_wdata_a : {128'b0, p_wdata_b};
            for (int w = 0; w < wpl; w++) begin
                chk("wb_data", ln[32*w +: 32], cpu_rd(d, base + 32'(4*w)));
                bk_mem[key(d, base + 32'(4*w))] = ln[32*w +: 32];
            end
        end else begin
            ln = '0;
            for (int w = 0; w < wpl; w++) ln[32*w +: 32] = bk_rd(d, base + 32'(4*w));
            if (d == 0) p_rdata_a = ln;
            else        p_rdata_b = ln[127:0];
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                cnt[d]    = 0;
                p_resp[d] = 1'b0;
            end else if (p_resp[d]) begin
                p_resp[d] = 1'b0;
            end else if (p_rd[d] || p_wr[d]) begin
                cnt[d]++;
                if (cnt[d] == 3) begin
                    cnt[d] = 0;
                    serve(d);
                    p_resp[d] = 1'b1;
                end
            end else begin
                cnt[d] = 0;
            end
        end
    end

    // Scoreboard pop on every response; strobe exclusivity while either is up.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (p_rd[d] || p_wr[d]) chk("strobes_exclusive", p_rd[d] & p_wr[d], 0);
                if (m_resp[d]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("resp_port", d, e.d);
                        chk("rdata", m_rdata[d], e.rdata);
                    end
                end
            end
        end
    end

    task automatic do_access(input vec_t v);
        logic [31:0] w;
        int          cyc, want_cyc, n, fi;
        logic        got;
        @(negedge clk);
        w = cpu_rd(v.d, v.addr);
        exp_q.push_back('{v.d, w});
        if (v.wr) begin
            for (int b = 0; b < 4; b++) if (v.be[b]) w[8*b +: 8] = v.wdata[8*b +: 8];
            cpu_mem[key(v.d, v.addr)] = w;
        end
        m_addr[v.d]  = v.addr;
        m_be[v.d]    = v.be;
        m_wdata[v.d] = v.wdata;
        m_rd[v.d]    = ~v.wr;
        m_wr[v.d]    = v.wr;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (m_resp[v.d]) got = 1'b1;
        end
        m_rd[v.d] = 1'b0;
        m_wr[v.d] = 1'b0;
        want_cyc = (v.kind == 0) ? 1 : (v.kind == 1) ? 5 : 9;
        chk("latency", cyc, want_cyc);
        @(posedge clk);
        n = v.kind;
        chk("pmem_event_count", ev_q.size(), n);
        if (v.kind == 2 && ev_q.size() >= 1) begin
            chk("wb_is_write", ev_q[0].wr, 1);
            chk("wb_addr", ev_q[0].a, v.wb_a);
        end
        fi = (v.kind == 2) ? 1 : 0;
        if (v.kind > 0 && ev_q.size() > fi) begin
            chk("fill_is_read", ev_q[fi].wr, 0);
            chk("fill_addr", ev_q[fi].a, v.fill_a);
        end
        ev_q.delete();
    endtask

    initial begin
        logic found;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = '0; m_rd[d] = 1'b0; m_wr[d] = 1'b0;
            m_be[d] = '0; m_wdata[d] = '0; p_resp[d] = 1'b0; cnt[d] = 0;
        end
        p_rdata_a = '0;
        p_rdata_b = '0;
        cpu_mem[key(0, 32'h1004)] = 32'hDEAD_BEEF;
        bk_mem[key(0, 32'h1004)]  = 32'hDEAD_BEEF;

        // 2-way, 32B lines, 8 sets
        vt.push_back(mk(0, 0, 32'h1004, 4'h0, 32'h0,         1, 32'h0,    32'h1000));
        vt.push_back(mk(0, 0, 32'h1004, 4'h0, 32'h0,         0, 32'h0,    32'h0));
        vt.push_back(mk(0, 1, 32'h1008, 4'h3, 32'h1234_5678, 0, 32'h0,    32'h0));
        vt.push_back(mk(0, 0, 32'h1008, 4'h0, 32'h0,         0, 32'h0,    32'h0));
        vt.push_back(mk(0, 0, 32'h2000, 4'h0, 32'h0,         1, 32'h0,    32'h2000));
        vt.push_back(mk(0, 0, 32'h1000, 4'h0, 32'h0,         0, 32'h0,    32'h0));
        vt.push_back(mk(0, 0, 32'h3000, 4'h0, 32'h0,         1, 32'h0,    32'h3000));
        vt.push_back(mk(0, 0, 32'h2000, 4'h0, 32'h0,         2, 32'h1000, 32'h2000));
        vt.push_back(mk(0, 1, 32'h3004, 4'hF, 32'hCAFE_F00D, 0, 32'h0,    32'h0));
        vt.push_back(mk(0, 1, 32'h2010, 4'h0, 32'hFFFF_FFFF, 0, 32'h0,    32'h0));
        vt.push_back(mk(0, 0, 32'h1000, 4'h0, 32'h0,         2, 32'h3000, 32'h1000));
        vt.push_back(mk(0, 0, 32'h2010, 4'h0, 32'h0,         0, 32'h0,    32'h0));
        vt.push_back(mk(0, 0, 32'h3004, 4'h0, 32'h0,         1, 32'h0,    32'h3000));
        vt.push_back(mk(0, 0, 32'h5000, 4'h0, 32'h0,         2, 32'h2000, 32'h5000));
        vt.push_back(mk(0, 0, 32'h1024, 4'h0, 32'h0,         1, 32'h0,    32'h1020));
        vt.push_back(mk(0, 0, 32'h1024, 4'h0, 32'h0,         0, 32'h0,    32'h0));
        vt.push_back(mk(0, 0, 32'h1000, 4'h0, 32'h0,         1, 32'h0,    32'h1000));
        // 4-way, 16B lines, 4 sets
        vt.push_back(mk(1, 0, 32'h1004, 4'h0, 32'h0,         1, 32'h0,    32'h1000));
        vt.push_back(mk(1, 0, 32'h2008, 4'h0, 32'h0,         1, 32'h0,    32'h2000));
        vt.push_back(mk(1, 0, 32'h300C, 4'h0, 32'h0,         1, 32'h0,    32'h3000));
        vt.push_back(mk(1, 1, 32'h4000, 4'hF, 32'h0BAD_C0DE, 1, 32'h0,    32'h4000));
        vt.push_back(mk(1, 0, 32'h1000, 4'h0, 32'h0,         0, 32'h0,    32'h0));
        vt.push_back(mk(1, 0, 32'h5000, 4'h0, 32'h0,         1, 32'h0,    32'h5000));
        vt.push_back(mk(1, 0, 32'h6000, 4'h0, 32'h0,         1, 32'h0,    32'h6000));
        vt.push_back(mk(1, 0, 32'h7000, 4'h0, 32'h0,         2, 32'h4000, 32'h7000));
        vt.push_back(mk(1, 0, 32'h4000, 4'h0, 32'h0,         1, 32'h0,    32'h4000));
        vt.push_back(mk(1, 0, 32'h5004, 4'h0, 32'h0,         0, 32'h0,    32'h0));
        vt.push_back(mk(1, 0, 32'h1014, 4'h0, 32'h0,         1, 32'h0,    32'h1010));

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mem_resp", m_resp[d], 0);
            chk("rst_mem_rdata", m_rdata[d], 0);
            chk("rst_pmem_read", p_rd[d], 0);
            chk("rst_pmem_write", p_wr[d], 0);
            chk("rst_pmem_address", p_addr[d], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) do_access(vt[i]);

        // Reset in the middle of a line fill.
        @(negedge clk);
        m_addr[0] = 32'h7000;
        m_be[0]   = 4'h0;
        m_rd[0]   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (p_rd[0]) found = 1'b1;
        end
        chk("fill_started", found, 1);
        chk("fill_addr_before_rst", p_addr[0], 32'h7000);
        rst = 1'b1;
        #1;
        chk("rst_drops_pmem_read", p_rd[0], 0);
        chk("rst_mem_resp_low", m_resp[0], 0);
        chk("rst_clears_pmem_address", p_addr[0], 0);
        m_rd[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("no_event_across_rst", ev_q.size(), 0);
        ev_q.delete();
        do_access(mk(0, 0, 32'h1000, 4'h0, 32'h0, 1, 32'h0, 32'h1000));

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_assoc_cache.md
# param_assoc_cache

Parametrised, write-back, write-allocate N-way set-associative cache that sits between the rv32i pipeline's 32-bit memory port and a line-wide physical memory port. It generalises the team's fixed direct-mapped geometry (24-bit tag, 3-bit index, 5-bit offset, 256-bit line) to configurable index and offset widths and way count. Replacement uses tree pseudo-LRU.

## Interface
- OFFSET_BITS, 5: byte-offset width. LINE_BITS = 8·2^OFFSET_BITS; must be ≥ 3.
- INDEX_BITS, 3: set-index width. SETS = 2^INDEX_BITS.
- WAYS, 2: associativity, one of 1, 2, 4. TAG_BITS = 32 − INDEX_BITS − OFFSET_BITS.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_address  in  32  CPU byte address; bits [1:0] ignored
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- mem_byte_enable  in  4  write byte lanes
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line-aligned physical address
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  LINE_BITS  writeback line
- pmem_rdata  in  LINE_BITS  fill line
- pmem_resp  in  1  physical memory completion pulse

## Operation
- Address split: tag = addr[31:INDEX_BITS+OFFSET_BITS], index = next INDEX_BITS, word select = addr[OFFSET_BITS-1:2].
- Per set, per way: valid, dirty, tag, line. Per set: WAYS−1 PLRU bits (none for WAYS=1).
- FSM states IDLE, CHECK, WRITEBACK, FILL.
- IDLE: on mem_read|mem_write, capture address, byte enables, wdata, op (write wins if both asserted) → CHECK.
- CHECK: hit = any way valid with matching tag (at most one). On hit: mem_resp=1, mem_rdata = selected word of hit line (pre-write value on writes); on write merge enabled bytes, set dirty; update PLRU to point away from hit way; → IDLE.
- CHECK miss: victim = lowest-numbered invalid way, else PLRU victim. Victim valid and dirty → WRITEBACK, else → FILL. No PLRU update on miss.
- WRITEBACK: pmem_write=1, pmem_address = {victim tag, index, 0}, pmem_wdata = victim line, held stable; on pmem_resp → FILL.
- FILL: pmem_read=1, pmem_address = {captured tag, index, 0}; on pmem_resp write pmem_rdata into victim way, valid=1, dirty=0, tag updated → CHECK (which then hits).
- PLRU, WAYS=2: bit = LRU way. WAYS=4: b0 selects pair (0 → ways 0/1), b1 within pair 0/1, b2 within pair 2/3; access sets bits to point away from accessed way.
- Outputs outside the stated states: mem_resp=0, mem_rdata=0, pmem_read=pmem_write=0, pmem_wdata=0; pmem_address holds last value.

## Timing
- Reset (async, immediate): state IDLE, all valid, dirty and PLRU bits 0, all outputs 0, pmem_address 0. Tag/data arrays not reset.
- Reset mid-WRITEBACK/FILL: pmem request drops at once; pending CPU request is lost; no partial line written.
- Hit latency: request sampled at edge k, mem_resp high in cycle k+1 (single cycle).
- Clean miss: FILL from cycle k+1; mem_resp one cycle after pmem_resp. Dirty miss adds the writeback transaction before fill.
- pmem_read/pmem_write stay high until the cycle pmem_resp is sampled; next state from following edge; never both high.
- CPU holds request stable until mem_resp and deasserts it the cycle after; a request still high in IDLE is a new request.
- mem_byte_enable=0 write: hit/miss handling unchanged, no data change, dirty still set.

## Test plan
- Reset then read 0x0000_1004 (WAYS=2): FILL with pmem_address 0x0000_1000; return line with word1=0xDEAD_BEEF → mem_rdata 0xDEAD_BEEF one cycle after pmem_resp; repeat read hits in 1 cycle, no pmem activity.
- Write 0x0000_1008, be=4'b0011, wdata 0x1234_5678 to resident line → mem_resp 1 cycle; read back gives {old[31:16],16'h5678}; dirty set.
- Fill ways with 0x1000 and 0x2000 (same set 0), touch 0x1000, access 0x3000 → victim way holding 0x2000 (clean: fill only, pmem_address 0x0000_3000).
- Dirty 0x1000 then force eviction → pmem_write at 0x0000_1000 with modified line, then pmem_read 0x3000; never both strobes high.
- WAYS=4, INDEX_BITS=2, OFFSET_BITS=4: access 4 conflicting lines then a fifth → PLRU victim matches tree model; pmem_address line-aligned to 16 B.
- Assert rst during FILL → pmem_read drops same cycle, mem_resp 0; previous 0x1000 access misses (valid cleared).
